// File: rtl/instruction_fetch.sv
// PC register and IF/ID pipeline register with stall, flush/redirect and HALT.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        pcSrc,
  input  logic [31:0] branchTarget,
  output logic [31:0] readAddress,
  input  logic [31:0] instruction,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pcPlus4,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [31:0] WRAP_ADDR = 32'(IMEM_WORDS * 4);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_seq_pc;
  logic [31:0] w_target;
  logic        w_is_halt;
  logic        w_load_fetch;
  logic        w_load_bubble;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_seq_pc   = (w_pc_plus4 == WRAP_ADDR) ? 32'd0 : w_pc_plus4;
  assign w_target   = branchTarget & ~32'h3;
  assign w_is_halt  = (instruction == HALT_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_RUN:  if (!pcSrc && !stall && w_is_halt) w_next_state = S_HALT;
      S_HALT: if (pcSrc) w_next_state = S_RUN;
      default: w_next_state = S_RUN;
    endcase
  end

  // Redirect beats stall beats halt-detect beats sequential fetch.
  always_comb begin
    w_next_pc     = r_pc;
    w_load_fetch  = 1'b0;
    w_load_bubble = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (pcSrc) begin
          w_next_pc     = w_target;
          w_load_bubble = 1'b1;
        end else if (stall) begin
          w_load_bubble = flush;
        end else if (w_is_halt) begin
          w_load_bubble = 1'b1;
        end else begin
          w_next_pc     = w_seq_pc;
          w_load_bubble = flush;
          w_load_fetch  = !flush;
        end
      end
      S_HALT: begin
        w_load_bubble = 1'b1;
        if (pcSrc) w_next_pc = w_target;
      end
      default: w_load_bubble = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_PC & ~32'h3;
    else        r_pc <= w_next_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr   <= NOP_WORD;
      ifid_pcPlus4 <= 32'd0;
      ifid_valid   <= 1'b0;
    end else if (w_load_bubble) begin
      ifid_instr   <= NOP_WORD;
      ifid_pcPlus4 <= 32'd0;
      ifid_valid   <= 1'b0;
    end else if (w_load_fetch) begin
      ifid_instr   <= instruction;
      ifid_pcPlus4 <= w_pc_plus4;
      ifid_valid   <= 1'b1;
    end
  end

  assign readAddress = r_pc;
  assign halted      = (r_state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (w_load_fetch)  fetch_count  <= fetch_count + 32'd1;
      if (w_load_bubble) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded random + directed bench for instruction_fetch.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_instruction_fetch;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_W  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pcSrc = 1'b0;
  logic [31:0] branchTarget = 32'd0;
  logic [31:0] readAddress;
  logic [31:0] instruction;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcPlus4;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  logic [31:0] mem [32];
  assign instruction = mem[readAddress[6:2]];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .flush(flush),
    .pcSrc(pcSrc),
    .branchTarget(branchTarget),
    .readAddress(readAddress),
    .instruction(instruction),
    .ifid_instr(ifid_instr),
    .ifid_pcPlus4(ifid_pcPlus4),
    .ifid_valid(ifid_valid),
    .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  typedef struct {
    logic [31:0] ra;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        v;
    logic        h;
  } exp_t;

  exp_t q[$];

  logic [31:0] m_pc, m_instr, m_pp4, m_fc, m_bc;
  logic        m_valid, m_halt;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP_W; m_pp4 = 32'd0;
    m_valid = 1'b0; m_halt = 1'b0; m_fc = 32'd0; m_bc = 32'd0;
  endtask

  task automatic bubble();
    m_instr = NOP_W; m_pp4 = 32'd0; m_valid = 1'b0; m_bc++;
  endtask

  // Next architectural state, straight from the fetch rules.
  task automatic model_step(logic ps, logic st, logic fl, logic [31:0] tgt);
    logic [31:0] ins;
    logic [31:0] nxt;
    ins = mem[m_pc[6:2]];
    nxt = m_pc + 32'd4;
    if (m_halt) begin
      bubble();
      if (ps) begin m_pc = {tgt[31:2], 2'b00}; m_halt = 1'b0; end
    end else if (ps) begin
      bubble();
      m_pc = {tgt[31:2], 2'b00};
    end else if (st) begin
      if (fl) bubble();
    end else if (ins == HALT_W) begin
      bubble();
      m_halt = 1'b1;
    end else begin
      if (fl) bubble();
      else begin m_instr = ins; m_pp4 = nxt; m_valid = 1'b1; m_fc++; end
      m_pc = (nxt == 32'd128) ? 32'd0 : nxt;
    end
  endtask

  // Called between edges; returns 2 time units after the modelled edge.
  task automatic step(logic ps, logic st, logic fl, logic [31:0] tgt);
    exp_t e;
    pcSrc = ps; stall = st; flush = fl; branchTarget = tgt;
    model_step(ps, st, fl, tgt);
    e.ra = m_pc; e.instr = m_instr; e.pp4 = m_pp4;
    e.v = m_valid; e.h = m_halt;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_readAddress", readAddress, e.ra);
      chk("sb_ifid_instr", ifid_instr, e.instr);
      chk("sb_ifid_pcPlus4", ifid_pcPlus4, e.pp4);
      chk("sb_ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
      chk("sb_halted", {31'd0, halted}, {31'd0, e.h});
    end
  end

  task automatic chk_reset_outs(string tag);
    chk({tag, "_readAddress"}, readAddress, 32'd0);
    chk({tag, "_ifid_instr"}, ifid_instr, NOP_W);
    chk({tag, "_ifid_pcPlus4"}, ifid_pcPlus4, 32'd0);
    chk({tag, "_ifid_valid"}, {31'd0, ifid_valid}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_fetch_count"}, fetch_count, 32'd0);
    chk({tag, "_bubble_count"}, bubble_count, 32'd0);
`endif
  endtask

  // Asserts reset between clock edges and checks outputs before any edge.
  task automatic mid_reset(string tag);
    rst_n = 1'b0;
    #1;
    chk_reset_outs(tag);
    model_reset();
    pcSrc = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h2108_0001 + (i << 16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic ps, st, fl;
    logic [31:0] tgt;
    fill_mem();
    model_reset();
    @(posedge clk);
    #2;
    chk_reset_outs("reset");
    rst_n = 1'b1;

    step(0, 0, 0, 0);
    chk("t1_instr0", ifid_instr, 32'h2108_0001);
    chk("t1_pp4_0", ifid_pcPlus4, 32'd4);
    step(0, 0, 0, 0);
    chk("t1_instr1", ifid_instr, 32'h2109_0001);
    step(0, 0, 0, 0);
    chk("t1_instr2", ifid_instr, 32'h210A_0001);
    chk("t1_pp4_2", ifid_pcPlus4, 32'd12);
    chk("t1_ra", readAddress, 32'd12);
`ifdef FETCH_PERF_CNT_EN
    chk("t1_fetch_count", fetch_count, 32'd3);
    chk("t1_bubble_count", bubble_count, 32'd0);
`endif

    mid_reset("t6");

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("t2_ra_hold", readAddress, 32'd8);
    chk("t2_instr_hold", ifid_instr, 32'h2109_0001);
    chk("t2_pp4_hold", ifid_pcPlus4, 32'd8);
    step(0, 0, 0, 0);
    chk("t2_release", ifid_instr, 32'h210A_0001);

    step(1, 1, 0, 32'h0000_0013);
    chk("t3_ra", readAddress, 32'h10);
    chk("t3_valid", {31'd0, ifid_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("t3_instr", ifid_instr, 32'h210C_0001);

    guard = 0;
    while (readAddress != 32'h7C && guard < 40) begin
      step(0, 0, 0, 0);
      guard++;
    end
    chk("t4_reach_7c", readAddress, 32'h7C);
    step(0, 0, 0, 0);
    chk("t4_wrap_ra", readAddress, 32'd0);
    chk("t4_pp4", ifid_pcPlus4, 32'h80);

    mid_reset("t5r");
    mem[3] = HALT_W;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_ra", readAddress, 32'd12);
    chk("t5_valid", {31'd0, ifid_valid}, 32'd0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("t5_still_halted", {31'd0, halted}, 32'd1);
    chk("t5_ra_frozen", readAddress, 32'd12);
    step(1, 0, 0, 32'd0);
    chk("t5_resume", {31'd0, halted}, 32'd0);
    chk("t5_resume_ra", readAddress, 32'd0);

    mid_reset("rnd_r");
    for (int i = 0; i < 32; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT_W : $urandom;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        mid_reset("rnd_mid");
      end else begin
        ps  = ($urandom_range(0, 7) == 0);
        st  = ($urandom_range(0, 3) == 0);
        fl  = ($urandom_range(0, 7) == 0);
        tgt = ($urandom_range(0, 15) == 0) ? $urandom
                                           : 32'($urandom_range(0, 127));
        step(ps, st, fl, tgt);
      end
    end

`ifdef FETCH_PERF_CNT_EN
    chk("end_fetch_count", fetch_count, m_fc);
    chk("end_bubble_count", bubble_count, m_bc);
`endif
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
